// File: rtl/fetch_mem_ctrl.sv
// IF-stage instruction-memory sequencer: one outstanding req/gnt/rvalid access per PCF,
// with stallF generation, a one-entry buffer for decode stalls and redirect kill handling.
module fetch_mem_ctrl #(
    parameter int             DPW = 32,
    parameter logic [DPW-1:0] NOP = DPW'(32'h0000_0013)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DPW-1:0] pc_f,
    input  logic           redirect_i,
    input  logic           stall_hz_i,
    output logic           stallF_o,
    output logic [DPW-1:0] instr_o,
    output logic           instr_valid_o,
    output logic           imem_req_o,
    output logic [DPW-1:0] imem_addr_o,
    input  logic           imem_gnt_i,
    input  logic           imem_rvalid_i,
    input  logic [DPW-1:0] imem_rdata_i,
    output logic [31:0]    fetch_cnt_o
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        KILL,
        HOLD
    } state_t;

    state_t         state;
    logic [DPW-1:0] hold_buf;
    logic [31:0]    cnt;
    logic           deliver;

    assign deliver = ((state == WAIT && imem_rvalid_i) || state == HOLD)
                     && !stall_hz_i && !redirect_i;

    // Outputs are forced to their idle values for as long as reset is held.
    always_comb begin
        instr_valid_o = 1'b0;
        instr_o       = NOP;
        stallF_o      = 1'b1;
        imem_req_o    = 1'b0;
        fetch_cnt_o   = '0;
        if (!rst) begin
            instr_valid_o = deliver;
            if (deliver) begin
                instr_o = (state == HOLD) ? hold_buf : imem_rdata_i;
            end
            stallF_o    = !(deliver || redirect_i);
            imem_req_o  = (state == REQ);
            fetch_cnt_o = cnt;
        end
    end

    assign imem_addr_o = pc_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            hold_buf <= '0;
            cnt      <= '0;
        end else begin
            if (deliver) begin
                cnt <= cnt + 32'd1;
            end
            case (state)
                REQ: begin
                    if (imem_gnt_i) begin
                        state <= redirect_i ? KILL : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (redirect_i) begin
                            state <= REQ;
                        end else if (stall_hz_i) begin
                            state    <= HOLD;
                            hold_buf <= imem_rdata_i;
                        end else begin
                            state <= REQ;
                        end
                    end else if (redirect_i) begin
                        state <= KILL;
                    end
                end
                // The granted access was for a stale PC; swallow its response.
                KILL: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                    end
                end
                HOLD: begin
                    if (redirect_i || !stall_hz_i) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule
